mem_bank_arbiter: RTL and testbench

//  Shares one single-port memory bank (1-cycle registered read, separate rd/wr addr buses, chip enable) among
//  NUM_REQ requesters. Grants at most one access per cycle using round-robin, with an optional lock for bursts.

---
 rtl/mem_bank_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_bank_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bank_arbiter.sv
// Round-robin arbiter sharing one single-port memory bank among NUM_REQ requesters,
// with burst lock and per-requester routing of the 1-cycle read response.
module mem_bank_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned DATA_W  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ-1:0]        req_lock,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_wr_en,
   output logic                      mem_rd_en,
   output logic                      mem_chip_en,
   output logic [ADDR_W-1:0]         mem_wr_addr,
   output logic [ADDR_W-1:0]         mem_rd_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   typedef enum logic {StArb, StLocked} state_e;

   state_e             state_q;
   logic [PTR_W-1:0]   rr_ptr_q;
   logic [PTR_W-1:0]   owner_q;
   logic [NUM_REQ-1:0] rsp_valid_q;

   logic [PTR_W-1:0]   win_idx;
   logic [PTR_W-1:0]   win_next;
   logic [PTR_W-1:0]   cand;
   int unsigned        scan_idx;
   logic               found;
   logic [ADDR_W-1:0]  sel_addr;

   // Winner selection: owner only while locked, otherwise first requester from rr_ptr upwards.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      scan_idx = 0;
      cand     = '0;
      if (state_q == StLocked) begin
         win_idx = owner_q;
         found   = req_valid[owner_q];
      end else begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand     = PTR_W'(scan_idx);
            if (!found && req_valid[cand]) begin
               found   = 1'b1;
               win_idx = cand;
            end
         end
      end
      if (rst) begin
         found = 1'b0;
      end
   end

   always_comb begin
      grant = '0;
      if (found) begin
         grant[win_idx] = 1'b1;
      end
   end

   assign win_next = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

   assign sel_addr    = found ? req_addr[int'(win_idx)*ADDR_W +: ADDR_W] : '0;
   assign mem_chip_en = found;
   assign mem_wr_en   = found & req_write[win_idx];
   assign mem_rd_en   = found & ~req_write[win_idx];
   assign mem_wr_addr = sel_addr;
   assign mem_rd_addr = sel_addr;
   assign mem_wdata   = found ? req_wdata[int'(win_idx)*DATA_W +: DATA_W] : '0;

   // Gating with rst drops an in-flight response in the same cycle reset is raised.
   assign rsp_valid = rsp_valid_q & {NUM_REQ{~rst}};
   assign rsp_rdata = mem_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StArb;
         rr_ptr_q    <= '0;
         owner_q     <= '0;
         rsp_valid_q <= '0;
      end else begin
         rsp_valid_q <= mem_rd_en ? grant : '0;
         unique case (state_q)
            StArb: begin
               if (found) begin
                  rr_ptr_q <= win_next;
                  if (req_lock[win_idx]) begin
                     state_q <= StLocked;
                     owner_q <= win_idx;
                  end
               end
            end
            StLocked: begin
               // Owner either accessed or idled this cycle; both release once lock drops.
               if (!req_lock[owner_q]) begin
                  state_q <= StArb;
               end
            end
            default: state_q <= StArb;
         endcase
      end
   end

`ifndef SYNTHESIS
   assert property (@(posedge clk) $onehot0(grant));
   assert property (@(posedge clk) (grant & ~req_valid) == '0);
   assert property (@(posedge clk) !(mem_wr_en && mem_rd_en));
   assert property (@(posedge clk) !((mem_wr_en || mem_rd_en) && !mem_chip_en));
   assert property (@(posedge clk) $onehot0(rsp_valid));
`endif

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter: grant sequence checks plus a scoreboard of read responses.
module tb_mem_bank_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_write;
   logic [N-1:0]    req_lock;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    grant;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_wr_en;
   logic            mem_rd_en;
   logic            mem_chip_en;
   logic [AW-1:0]   mem_wr_addr;
   logic [AW-1:0]   mem_rd_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata;

   mem_bank_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_lock    (req_lock),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .grant       (grant),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .mem_wr_en   (mem_wr_en),
      .mem_rd_en   (mem_rd_en),
      .mem_chip_en (mem_chip_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_rd_addr (mem_rd_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] pat(input int unsigned a);
      return DW'(a * 37) ^ 16'hC3A5;
   endfunction

   // Bank model: unwritten locations read back the fixed pattern.
   logic [DW-1:0] bank [1024];
   logic [1023:0] written = '0;
   always @(posedge clk) begin
      if (mem_wr_en) begin
         bank[mem_wr_addr]    <= mem_wdata;
         written[mem_wr_addr] <= 1'b1;
      end
      if (mem_rd_en) begin
         mem_rdata <= written[mem_rd_addr] ? bank[mem_rd_addr] : pat(32'(mem_rd_addr));
      end
   end

   logic [DW-1:0] ref_mem [1024];

   typedef struct {
      int unsigned   idx;
      logic [DW-1:0] data;
      int unsigned   cyc;
   } rsp_t;
   rsp_t sb[$];
   rsp_t got;

   always @(negedge clk) begin
      if (rsp_valid != '0) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid=%b cycle %0d, required no response", rsp_valid, cyc);
         end else begin
            got = sb.pop_front();
            if (rsp_valid !== (4'b0001 << got.idx) || rsp_rdata !== got.data || cyc != got.cyc) begin
               errors++;
               $display("FAIL rsp: rsp_valid=%b rdata=%h cycle %0d, required %b %h cycle %0d",
                        rsp_valid, rsp_rdata, cyc, 4'b0001 << got.idx, got.data, got.cyc);
            end
         end
      end
   end

   task automatic set_req(input int i, input bit wr, input bit lk, input int unsigned a,
                          input logic [DW-1:0] d);
      req_write[i]           = wr;
      req_lock[i]            = lk;
      req_addr[i*AW +: AW]   = AW'(a);
      req_wdata[i*DW +: DW]  = d;
   endtask

   // One cycle: check grant/bank at negedge, record expected response, advance past posedge.
   task automatic step(input logic [N-1:0] exp_g, input bit exp_rsp, input bit chk_rsp0,
                       input string name);
      logic [AW-1:0] a;
      @(negedge clk);
      checks++;
      if (grant !== exp_g) begin
         errors++;
         $display("FAIL %s grant: got %b, required %b", name, grant, exp_g);
      end
      checks++;
      if (mem_chip_en !== (exp_g != '0)) begin
         errors++;
         $display("FAIL %s chip_en: got %b, required %b", name, mem_chip_en, exp_g != '0);
      end
      checks++;
      if ((mem_wr_en && mem_rd_en) || ((mem_wr_en || mem_rd_en) && !mem_chip_en)) begin
         errors++;
         $display("FAIL %s bank_en: wr=%b rd=%b ce=%b, required exclusive and within chip_en",
                  name, mem_wr_en, mem_rd_en, mem_chip_en);
      end
      if (chk_rsp0) begin
         checks++;
         if (rsp_valid !== '0) begin
            errors++;
            $display("FAIL %s rsp_dropped: got %b, required 0000", name, rsp_valid);
         end
      end
      for (int i = 0; i < int'(N); i++) begin
         if (exp_g[i]) begin
            a = req_addr[i*AW +: AW];
            if (req_write[i]) ref_mem[a] = req_wdata[i*DW +: DW];
            else if (exp_rsp) sb.push_back('{32'(i), ref_mem[a], cyc + 1});
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) ref_mem[a] = pat(32'(a));
      rst       = 1'b1;
      req_valid = 4'b1111;
      req_write = '0;
      req_lock  = '0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < int'(N); i++) set_req(i, 1'b0, 1'b0, 32'h10 + 32'(i), '0);

      // Reset held with every requester active
      for (int k = 0; k < 3; k++) step(4'b0000, 1'b0, 1'b1, "reset");
      rst = 1'b0;

      // Round robin, all reads
      for (int k = 0; k < 8; k++) step(4'b0001 << (k % 4), 1'b1, 1'b0, "rr");
      req_valid = '0;
      step(4'b0000, 1'b0, 1'b0, "idle");

      // Write then read-back by another requester
      set_req(2, 1'b1, 1'b0, 32'h05, 16'hBEEF);
      req_valid = 4'b0100;
      step(4'b0100, 1'b1, 1'b0, "wr_beef");
      set_req(1, 1'b0, 1'b0, 32'h05, '0);
      req_valid = 4'b0010;
      step(4'b0010, 1'b1, 1'b0, "rd_beef");

      // Simultaneous write (req0) and read (req3): only the winner is serviced
      set_req(0, 1'b1, 1'b0, 32'h07, 16'h1234);
      set_req(3, 1'b0, 1'b0, 32'h07, '0);
      req_valid = 4'b1001;
      step(4'b1000, 1'b1, 1'b0, "wr_rd_clash");
      req_valid = 4'b0001;
      step(4'b0001, 1'b1, 1'b0, "clash_wr");
      req_valid = 4'b1000;
      step(4'b1000, 1'b1, 1'b0, "clash_rdback");

      // Move rr_ptr to 3, then a locked burst from req 3 while 0-2 compete
      set_req(0, 1'b0, 1'b0, 32'h10, '0);
      set_req(2, 1'b0, 1'b0, 32'h12, '0);
      req_valid = 4'b0100;
      step(4'b0100, 1'b1, 1'b0, "pre_lock");
      req_valid = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         set_req(3, 1'b1, k < 3, 32'h40 + 32'(k), 16'hA000 + 16'(k));
         step(4'b1000, 1'b1, 1'b0, "lock_burst");
      end
      req_valid = 4'b0111;
      step(4'b0001, 1'b1, 1'b0, "post_lock");
      req_valid = '0;
      step(4'b0000, 1'b0, 1'b0, "idle2");
      set_req(1, 1'b0, 1'b0, 32'h42, '0);
      req_valid = 4'b0010;
      step(4'b0010, 1'b1, 1'b0, "lock_rdback");

      // Locked read from req 2, then reset before its response
      set_req(2, 1'b0, 1'b1, 32'h13, '0);
      req_valid = 4'b0100;
      step(4'b0100, 1'b0, 1'b0, "rd_before_rst");
      rst = 1'b1;
      set_req(2, 1'b0, 1'b0, 32'h13, '0);
      req_valid = 4'b1111;
      step(4'b0000, 1'b0, 1'b1, "rst_mid_read");
      rst = 1'b0;
      step(4'b0001, 1'b1, 1'b0, "after_rst");

      // Withdrawn request, then sparse requests from req 3 only
      req_valid = 4'b0101;
      step(4'b0100, 1'b1, 1'b0, "pre_withdraw");
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b0, "withdraw");
      set_req(3, 1'b0, 1'b0, 32'h21, '0);
      req_valid = 4'b1000;
      step(4'b1000, 1'b1, 1'b0, "sparse1");
      req_valid = 4'b0000;
      step(4'b0000, 1'b0, 1'b0, "sparse_gap");
      set_req(3, 1'b0, 1'b0, 32'h05, '0);
      req_valid = 4'b1000;
      step(4'b1000, 1'b1, 1'b0, "sparse2");
      req_valid = 4'b0000;
      for (int k = 0; k < 3; k++) step(4'b0000, 1'b0, 1'b0, "drain");

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_rsp: %0d responses outstanding, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
